// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master drives operands and start; the slave (sequencer) returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry, ovf, zero
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder stage fed LSB-first over WIDTH clocks,
// with a carry flip-flop between bits and registered result/flags on completion.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] final_sum;
  logic [CW-1:0]    cnt;
  logic             carry_ff;
  logic             fa_sum;
  logic             fa_carry;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  assign load      = bus.start && (state == IDLE || state == DONE);
  assign last_bit  = (state == RUN) && (cnt == LAST);
  assign fa_sum    = a_sr[0] ^ b_sr[0] ^ carry_ff;
  assign fa_carry  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_ff) | (b_sr[0] & carry_ff);
  assign final_sum = {fa_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: invert B on load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      carry_ff <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (load) begin
      a_sr     <= bus.a;
      b_sr     <= bus.sub ? ~bus.b : bus.b;
      carry_ff <= bus.sub;
      cnt      <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= final_sum;
      carry_ff <= fa_carry;
      cnt      <= cnt + CW'(1);
      // On the MSB, carry_ff still holds the carry into the MSB.
      if (last_bit) begin
        sum_q   <= final_sum;
        carry_q <= fa_carry;
        ovf_q   <= carry_ff ^ fa_carry;
        zero_q  <= (final_sum == '0);
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: stimulus pushes hand-computed results into a
// scoreboard queue, and a monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;
    int               done_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cnt;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(WIDTH)) ifc ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one start edge; returns #1 after that edge with start already dropped.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                                input logic [WIDTH-1:0] e_sum, input logic e_carry, input logic e_ovf,
                                input logic e_zero, input bit expect_done);
    exp_t e;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
    ifc.sub   = sub;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    if (expect_done) begin
      e.sum      = e_sum;
      e.carry    = e_carry;
      e.ovf      = e_ovf;
      e.zero     = e_zero;
      e.done_cyc = cyc + WIDTH;
      sb.push_back(e);
    end
  endtask

  // Monitor: counts the busy run preceding each done and checks the popped expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else if (ifc.busy) begin
      busy_cnt++;
    end else if (ifc.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check_output("sum", 32'(ifc.sum), 32'(e.sum));
        check_output("carry", 32'(ifc.carry), 32'(e.carry));
        check_output("ovf", 32'(ifc.ovf), 32'(e.ovf));
        check_output("zero", 32'(ifc.zero), 32'(e.zero));
        check_output("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check_output("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  initial begin
    int guard;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    rst       = 1'b1;
    ifc.start = 1'b1;
    ifc.sub   = 1'b0;
    ifc.a     = 8'h12;
    ifc.b     = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(ifc.busy), 32'd0);
    check_output("reset_done", 32'(ifc.done), 32'd0);
    check_output("reset_sum", 32'(ifc.sum), 32'd0);
    check_output("reset_flags", {29'd0, ifc.carry, ifc.ovf, ifc.zero}, 32'd0);
    ifc.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);

    apply_stimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    check_output("hold_sum_idle", 32'(ifc.sum), 32'h96);
    check_output("hold_ovf_idle", 32'(ifc.ovf), 32'd1);

    apply_stimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (WIDTH + 3) @(posedge clk);
    apply_stimulus(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (WIDTH + 3) @(posedge clk);
    apply_stimulus(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (WIDTH + 3) @(posedge clk);

    // start during RUN must be ignored, and operand changes must not disturb the op
    apply_stimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.a     = 8'hFF;
    ifc.b     = 8'hFF;
    ifc.sub   = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.a     = 8'h55;
    ifc.b     = 8'hAA;
    repeat (WIDTH + 3) @(posedge clk);

    // back-to-back: second start lands in the DONE cycle of the first
    apply_stimulus(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (WIDTH) @(posedge clk);
    apply_stimulus(8'h0A, 8'h0B, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("b2b_busy", 32'(ifc.busy), 32'd1);
    repeat (WIDTH + 3) @(posedge clk);

    // mid-operation reset aborts without a done pulse and clears the result
    apply_stimulus(8'h33, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("abort_busy", 32'(ifc.busy), 32'd0);
    check_output("abort_done", 32'(ifc.done), 32'd0);
    check_output("abort_sum", 32'(ifc.sum), 32'd0);
    check_output("abort_flags", {29'd0, ifc.carry, ifc.ovf, ifc.zero}, 32'd0);
    repeat (WIDTH + 4) @(posedge clk);

    apply_stimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    guard = 0;
    while (sb.size() != 0 && guard < 4 * WIDTH) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer around a single 1-bit full adder stage (sum = a^b^c, carry = majority).
- Sequences WIDTH operand bits LSB-first through that stage over WIDTH clocks, holding the carry in a flip-flop between bits.
- Used in the ALU where area matters more than latency; provides a start/busy/done handshake plus registered result and flags.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request a new operation; sampled only in IDLE or DONE.
- sub_i  input  1  0 = a+b, 1 = a-b; sampled together with start_i.
- a_i  input  WIDTH  operand A; sampled together with start_i.
- b_i  input  WIDTH  operand B; sampled together with start_i.
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle pulse; result and flags valid from this cycle onward.
- sum_o  output  WIDTH  registered result.
- carry_o  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf_o  output  1  signed (two's-complement) overflow.
- zero_o  output  1  sum_o == 0.

Behaviour:
- Reset (rst_i=1 at an edge): state = IDLE. busy_o, done_o, sum_o, carry_o, ovf_o and zero_o all = 0. Shift registers, bit counter and carry FF = 0. Reset overrides start_i. Mid-operation reset aborts with no done_o.
- State IDLE:
  - start_i=1 at edge E0: load A shift reg = a_i. Load B shift reg = sub_i ? ~b_i : b_i. Carry FF = sub_i. Counter = 0. Go to RUN.
  - Otherwise stay in IDLE.
- State RUN: busy_o=1. Each edge:
  - Full-adder over (A[0], B[0], carry FF).
  - Sum bit shifts into the MSB of the result shift reg; result reg shifts right.
  - A and B shift right; carry FF takes the adder carry; counter increments.
  - Bits are processed at edges E1..E_WIDTH.
  - At E_WIDTH (counter == WIDTH-1):
    - Transfer the final result to sum_o; carry_o = final carry.
    - ovf_o = (carry into MSB) XOR (carry out of MSB).
    - zero_o = (final sum == 0).
    - Go to DONE.
  - start_i during RUN is ignored; the operation is not restarted and no error is raised.
- State DONE: done_o=1 and busy_o=0 for exactly this cycle.
  - start_i=1 behaves as in IDLE (back-to-back; next state RUN).
  - Otherwise go to IDLE.
- Latency: start sampled at E0 gives busy_o high for WIDTH cycles after E0, and done_o high in the cycle after E_WIDTH. Total is WIDTH+1 cycles from start to done; throughput is one op per WIDTH+1 cycles.
- Outputs sum_o, carry_o, ovf_o and zero_o change only at the completion edge or at reset. They hold their values across IDLE, DONE and the following RUN until the next completion.
- a_i, b_i and sub_i may change freely after E0 without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x3C, sub=0:
  - busy_o high 8 cycles, done_o one-cycle pulse 9 cycles after start edge.
  - sum_o=0x96, carry_o=0, ovf_o=1, zero_o=0.
- a=0xFF, b=0x01, sub=0 -> sum_o=0x00, carry_o=1, ovf_o=0, zero_o=1.
- Subtract cases:
  - a=0x10, b=0x20, sub=1 -> sum_o=0xF0, carry_o=0 (borrow), ovf_o=0, zero_o=0.
  - a=0x80, b=0x01, sub=1 -> sum_o=0x7F, carry_o=1, ovf_o=1.
- Start 0x01+0x01. Pulse start_i with a=0xFF, b=0xFF at cycle 3 of RUN, and change a_i/b_i during RUN -> ignored; result 0x02, single done_o pulse at the normal cycle.
- Start 0x05+0x03, then raise start_i in the DONE cycle with 0x0A-0x0B:
  - First done gives 0x08; busy_o re-asserts the next cycle.
  - Second done 9 cycles later gives 0xFF, carry_o=0, ovf_o=0.
- Assert rst_i for one cycle at cycle 4 of RUN -> next cycle all outputs 0, state IDLE, no done_o. A subsequent 0x7F+0x01 yields 0x80, ovf_o=1.
